// File: rtl/booth_pkg.sv
// booth_pkg: shared defaults, response-FIFO depth derivation and the in-flight tag type
// used by booth_mul_arbiter and its response FIFO.
package booth_pkg;

  localparam int BITWIDTH_DEF = 16;
  localparam int MUL_LAT_DEF  = 2;
  localparam int NREQ_DEF     = 4;
  localparam int ID_W         = $clog2(NREQ_DEF);

  // Enough slots for every tag in the pipeline plus slack so a full pipe never stalls issue.
  function automatic int fifo_depth(input int mul_lat);
    return mul_lat + 3;
  endfunction

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/booth_rsp_fifo.sv
// booth_rsp_fifo: synchronous FIFO with wrapping pointers and an exposed occupancy count.
module booth_rsp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 5,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    do_pop = pop && (cnt_q != '0);
    mem_d  = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && do_pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one pipelined Booth multiplier among NREQ requesters with tagged,
// credit-protected in-order responses. Define BOOTH_ARB_RR_EN for round-robin, else fixed priority.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int NREQ     = NREQ_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*BITWIDTH-1:0]   req_a,
  input  logic [NREQ*BITWIDTH-1:0]   req_b,
  output logic [BITWIDTH-1:0]        mul_a,
  output logic [BITWIDTH-1:0]        mul_b,
  input  logic [2*BITWIDTH-1:0]      mul_product,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [2*BITWIDTH-1:0]      rsp_product,
  output logic                       busy
);

  localparam int FIFO_DEPTH = fifo_depth(MUL_LAT);
  localparam int IDW        = $clog2(NREQ);
  localparam int PRW        = 2 * BITWIDTH;
  localparam int FW         = IDW + PRW;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  tag_t                tag_q [MUL_LAT+1];
  tag_t                tag_d [MUL_LAT+1];
  logic [BITWIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [IDW-1:0]      start_idx, cand, gnt_id;
  logic                gnt_found, gnt_vld, credit_ok;
  logic [CW-1:0]       fifo_cnt;
  logic [FW-1:0]       fifo_dout;
  int                  inflight;

`ifdef BOOTH_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign start_idx = ptr_q;
`else
  assign start_idx = '0;
`endif

  // Scan starts at start_idx; with fixed priority that is always requester 0.
  always_comb begin
    cand      = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(start_idx) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Credits use pre-pop occupancy, so a pop frees its slot only from the next cycle.
  always_comb begin
    inflight = 0;
    for (int j = 0; j <= MUL_LAT; j++)
      if (tag_q[j].valid) inflight = inflight + 1;
    credit_ok = reset && ((inflight + int'(fifo_cnt)) < FIFO_DEPTH);
    gnt_vld   = gnt_found && credit_ok;
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
    busy = (inflight != 0) || (fifo_cnt != '0);
  end

  always_comb begin
    mul_a_d  = gnt_vld ? req_a[int'(gnt_id)*BITWIDTH +: BITWIDTH] : mul_a_q;
    mul_b_d  = gnt_vld ? req_b[int'(gnt_id)*BITWIDTH +: BITWIDTH] : mul_b_q;
    tag_d[0] = '{valid: gnt_vld, id: gnt_id};
    for (int j = 1; j <= MUL_LAT; j++) tag_d[j] = tag_q[j-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      for (int j = 0; j <= MUL_LAT; j++) tag_q[j] <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      tag_q   <= tag_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  booth_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_q[MUL_LAT].valid),
    .din   ({tag_q[MUL_LAT].id, mul_product}),
    .pop   (rsp_ready),
    .dout  (fifo_dout),
    .valid (rsp_valid),
    .count (fifo_cnt)
  );

  assign rsp_id      = fifo_dout[FW-1:PRW];
  assign rsp_product = fifo_dout[PRW-1:0];

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Shares one signed BITWIDTH×BITWIDTH Booth multiplier among NREQ requesters. It arbitrates requests with a valid/ready handshake, issues operands to the multiplier, and tracks each in-flight operation with a requester tag through the multiplier's fixed latency. Products are buffered in a credit-protected response FIFO, so backpressure on the response side never drops a result. The block sits between the multiplier and the client blocks that issue multiplies.

## Interface
- BITWIDTH, 16: operand width; products are 2*BITWIDTH.
- NREQ, 4: number of requesters (≥2).
- MUL_LAT, 2: multiplier latency in cycles, from operands presented to product valid.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request.
- req_ready  output  NREQ  one-hot grant; the handshake completes when req_valid[i] and req_ready[i] are both high at a rising edge.
- req_a, req_b  input  NREQ*BITWIDTH  packed operands; requester i uses slice [i*BITWIDTH +: BITWIDTH].
- mul_a, mul_b  output  BITWIDTH  registered operands to the multiplier.
- mul_product  input  2*BITWIDTH  multiplier result.
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  consumer accepts the head.
- rsp_id  output  clog2(NREQ)  requester index of the head.
- rsp_product  output  2*BITWIDTH  product of the head, forwarded unchanged.
- busy  output  1  high while any operation is in flight or the FIFO is non-empty.

## Operation
- Arbiter grants at most one requester per cycle, and only when req_valid is high for that requester and a credit is available.
- Requesters hold req_valid and their operands stable until granted. req_ready is combinational from req_valid, the arbitration pointer and the credit state.
- On grant, the arbiter registers the selected operands into mul_a/mul_b and pushes {valid=1, id} into a tag shift register of length MUL_LAT+1. With no grant, it pushes valid=0; mul_a/mul_b hold their value.
- When a tag with valid=1 exits the shift register, mul_product is written to the FIFO together with that id. Products whose tag has valid=0 are ignored.
- Response FIFO: FIFO_DEPTH = MUL_LAT+3 entries. The head is presented on rsp_*. It pops when rsp_valid && rsp_ready.
- Credit rule: issue only when (in-flight count + FIFO count) < FIFO_DEPTH. Counts are sampled before this cycle's pop, so a simultaneous pop does not free a credit in the same cycle. The FIFO therefore never overflows.
- Responses return in issue order. No reordering is done.
- Arithmetic: operands and product are two's-complement. The block does no sign handling, truncation or rounding.

## Timing
- Grant at edge t. mul_a/mul_b are valid during cycle t+1. The product is captured into the FIFO at edge t+1+MUL_LAT. rsp_valid is high from cycle t+2+MUL_LAT.
- Grant-to-response latency is MUL_LAT+2 cycles when the FIFO is empty.
- Sustained throughput with rsp_ready held high is one grant per cycle.
- If rsp_ready is held low, grants stop once credits are exhausted. At most FIFO_DEPTH operations are outstanding. Issue resumes the cycle after the credit count drops.
- Simultaneous FIFO push and pop: both occur and the count is unchanged. FIFO pointers wrap modulo FIFO_DEPTH.
- Reset values: req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0. The tag pipeline is cleared, FIFO pointers and counts are 0, and the RR pointer is 0.
- Reset mid-operation: all in-flight tags and buffered results are discarded. Products emerging after reset deassertion carry valid=0 tags and are dropped.

## Configuration
- BOOTH_ARB_RR_EN defined: round-robin arbitration. The pointer advances to one past the granted index after each grant. No requester waits more than NREQ-1 grants.
- BOOTH_ARB_RR_EN undefined: fixed priority, where the lowest asserted index wins. The RR pointer register is not built.

## Structure
- Package booth_pkg holds:
  - the default BITWIDTH and MUL_LAT constants;
  - the FIFO_DEPTH derivation;
  - the tag typedef {valid, id}.
- Sub-module booth_rsp_fifo is the synchronous FIFO, parameterised by width and depth and exposing its count. The arbiter, tag pipeline and credit logic stay in the top module.

## Test plan
- Single request, requester 2, a=3, b=-5 (0xFFFB):
  - req_ready[2] is high in the same cycle;
  - rsp_valid follows MUL_LAT+2 cycles later with rsp_id=2, rsp_product=0xFFFFFFF1.
- All four requesters valid continuously, a=i+1, b=10, rsp_ready=1:
  - with RR enabled, grants rotate 0,1,2,3,0…, one per cycle;
  - with RR disabled, only requester 0 is granted.
- rsp_ready=0 with all requesters valid:
  - exactly FIFO_DEPTH (5) grants, then req_ready stays 0;
  - raising rsp_ready drains 5 results in order with no loss, then issue resumes.
- Extremes: a=0x8000, b=0x8000 → 0x40000000. a=0x7FFF, b=0x8000 → 0xC0008000. a=0, b=0x1234 → 0.
- Reset asserted while 3 operations are in flight:
  - every output returns to its reset value asynchronously;
  - after release, no stale rsp_valid appears within 2*MUL_LAT+4 cycles.
- Simultaneous push and pop with rsp_ready toggling every cycle: FIFO count stays bounded ≤5, busy falls 1 cycle after the last pop, and ordering is preserved.
